// File: rtl/slot_game_ctrl.sv
// slot_game_ctrl
// Slot machine game controller: coin credit, start/stop sequencing of the
// three reels, and payout evaluation. Every output is a register.
//
// state  | meaning
// S_IDLE | waiting for a start event, all reels frozen
// S_SPIN | all three reels spinning
// S_ST1  | reel 1 frozen, reels 2 and 3 spinning
// S_ST2  | reels 1 and 2 frozen, reel 3 spinning
// S_EVAL | all reels frozen, one cycle: sample reels and apply payout
// S_OVER | credit reached 99, left only by reset
module slot_game_ctrl #(
    parameter int INIT_COIN   = 74,
    parameter int BET         = 1,
    parameter int PAIR_PAY    = 2,
    parameter int JACKPOT_PAY = 10,
    parameter int AUTO_STOP   = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       C_IN,
    input  logic       GAME_START,
    input  logic       STOP_BTN,
    input  logic [3:0] REEL1,
    input  logic [3:0] REEL2,
    input  logic [3:0] REEL3,
    output logic       STOP1,
    output logic       STOP2,
    output logic       STOP3,
    output logic [6:0] COIN,
    output logic [1:0] GAMESET,
    output logic [1:0] WIN
);

    typedef enum logic [2:0] {
        S_IDLE, S_SPIN, S_ST1, S_ST2, S_EVAL, S_OVER
    } state_t;

    localparam int              CNT_W     = $clog2(AUTO_STOP);
    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_STOP - 1);
    localparam logic [6:0]      COIN_MAX  = 7'd99;

    state_t           state;
    logic             c_in_q;
    logic             start_q;
    logic             stop_q;
    logic [CNT_W-1:0] auto_cnt;

    logic       coin_ev;
    logic       start_ev;
    logic       btn_ev;
    logic       running;
    logic       auto_ev;
    logic       stop_ev;
    logic       start_ok;
    logic       coin_acc;
    logic       jackpot;
    logic       pair;
    logic [1:0] win_calc;
    logic [8:0] payout;
    logic [8:0] sum;
    logic [6:0] new_coin;
    logic       hit_max;

    // Edge events, stop sources, reel match and next credit value
    always_comb begin
        coin_ev  = C_IN & ~c_in_q;
        start_ev = GAME_START & ~start_q;
        btn_ev   = STOP_BTN & ~stop_q;
        running  = (state == S_SPIN) || (state == S_ST1) || (state == S_ST2);
        auto_ev  = running && (auto_cnt == AUTO_LAST);
        stop_ev  = running && (btn_ev || auto_ev);
        start_ok = (state == S_IDLE) && start_ev && ({25'd0, COIN} >= BET);
        coin_acc = coin_ev && (state != S_OVER);

        jackpot  = (REEL1 == REEL2) && (REEL2 == REEL3);
        pair     = !jackpot && ((REEL1 == REEL2) || (REEL1 == REEL3) || (REEL2 == REEL3));
        win_calc = jackpot ? 2'd2 : (pair ? 2'd1 : 2'd0);

        payout = 9'd0;
        if (state == S_EVAL) begin
            if (jackpot) begin
                payout = 9'(JACKPOT_PAY);
            end else if (pair) begin
                payout = 9'(PAIR_PAY);
            end
        end

        // 9-bit sum keeps coin + payout headroom before saturating at 99
        sum = {2'b00, COIN} + {8'd0, coin_acc} + payout;
        if (start_ok) begin
            sum = sum - 9'(BET);
        end
        new_coin = (sum > 9'd99) ? COIN_MAX : sum[6:0];
        hit_max  = coin_acc && (new_coin == COIN_MAX);
    end

    // Game FSM with registered outputs, credit register, input history and auto-stop timer
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            COIN     <= 7'(INIT_COIN);
            GAMESET  <= 2'd0;
            STOP1    <= 1'b1;
            STOP2    <= 1'b1;
            STOP3    <= 1'b1;
            WIN      <= 2'd0;
            c_in_q   <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            auto_cnt <= '0;
        end else begin
            c_in_q  <= C_IN;
            start_q <= GAME_START;
            stop_q  <= STOP_BTN;
            COIN    <= new_coin;

            // counts idle cycles while spinning; any stop or state entry restarts it
            if (running && !stop_ev && !hit_max) begin
                auto_cnt <= auto_cnt + CNT_W'(1);
            end else begin
                auto_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (hit_max) begin
                        state   <= S_OVER;
                        GAMESET <= 2'd2;
                    end else if (start_ok) begin
                        state   <= S_SPIN;
                        GAMESET <= 2'd1;
                        STOP1   <= 1'b0;
                        STOP2   <= 1'b0;
                        STOP3   <= 1'b0;
                        WIN     <= 2'd0;
                    end
                end
                S_SPIN, S_ST1, S_ST2: begin
                    // reaching 99 abandons the running game without payout
                    if (hit_max) begin
                        state   <= S_OVER;
                        GAMESET <= 2'd2;
                        STOP1   <= 1'b1;
                        STOP2   <= 1'b1;
                        STOP3   <= 1'b1;
                    end else if (stop_ev) begin
                        if (state == S_SPIN) begin
                            state <= S_ST1;
                            STOP1 <= 1'b1;
                        end else if (state == S_ST1) begin
                            state <= S_ST2;
                            STOP2 <= 1'b1;
                        end else begin
                            state <= S_EVAL;
                            STOP3 <= 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    WIN <= win_calc;
                    if (new_coin == COIN_MAX) begin
                        state   <= S_OVER;
                        GAMESET <= 2'd2;
                    end else begin
                        state   <= S_IDLE;
                        GAMESET <= 2'd0;
                    end
                end
                S_OVER: begin
                    state <= S_OVER;
                end
                default: begin
                    state   <= S_IDLE;
                    GAMESET <= 2'd0;
                    STOP1   <= 1'b1;
                    STOP2   <= 1'b1;
                    STOP3   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Testbench for slot_game_ctrl: game-level reference model checked every
// cycle, plus hand-computed literal expectations along a directed scenario.
module tb_slot_game_ctrl;

    localparam int INIT = 74;
    localparam int BETV = 1;
    localparam int PP   = 2;
    localparam int JP   = 10;
    localparam int AUTO = 8;

    logic       CLK;
    logic       RST;
    logic       C_IN;
    logic       GAME_START;
    logic       STOP_BTN;
    logic [3:0] REEL1, REEL2, REEL3;
    logic       STOP1, STOP2, STOP3;
    logic [6:0] COIN;
    logic [1:0] GAMESET;
    logic [1:0] WIN;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    slot_game_ctrl #(
        .INIT_COIN(INIT), .BET(BETV), .PAIR_PAY(PP), .JACKPOT_PAY(JP), .AUTO_STOP(AUTO)
    ) dut (
        .CLK(CLK), .RST(RST), .C_IN(C_IN), .GAME_START(GAME_START), .STOP_BTN(STOP_BTN),
        .REEL1(REEL1), .REEL2(REEL2), .REEL3(REEL3),
        .STOP1(STOP1), .STOP2(STOP2), .STOP3(STOP3),
        .COIN(COIN), .GAMESET(GAMESET), .WIN(WIN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    // Game-level reference: credit, whether a game is running, how many reels are stopped
    int m_coin, m_win, m_stopped, m_idle;
    bit m_active, m_over;
    bit p_c, p_s, p_b;

    always @(posedge CLK) begin
        bit ce, se, be, startok, stopev;
        int n_eq, pay, newc;
        if (!RST) begin
            m_coin = INIT; m_win = 0; m_stopped = 0; m_idle = 0;
            m_active = 0; m_over = 0; p_c = 0; p_s = 0; p_b = 0;
        end else begin
            ce = C_IN && !p_c;
            se = GAME_START && !p_s;
            be = STOP_BTN && !p_b;
            p_c = C_IN; p_s = GAME_START; p_b = STOP_BTN;
            if (m_over) begin
                // frozen until reset
            end else if (m_active && m_stopped == 3) begin
                n_eq = int'(REEL1 == REEL2) + int'(REEL1 == REEL3) + int'(REEL2 == REEL3);
                pay   = (n_eq == 3) ? JP : ((n_eq == 1) ? PP : 0);
                m_win = (n_eq == 3) ? 2 : ((n_eq == 1) ? 1 : 0);
                m_coin = sat(m_coin + pay + int'(ce));
                m_active = 0;
                m_stopped = 0;
                if (m_coin == 99) m_over = 1;
            end else begin
                startok = !m_active && se && (m_coin >= BETV);
                stopev  = m_active && (be || m_idle == AUTO - 1);
                newc = sat(m_coin + int'(ce) - (startok ? BETV : 0));
                if (ce && newc == 99) begin
                    m_over = 1;
                    m_active = 0;
                end else if (startok) begin
                    m_active = 1; m_stopped = 0; m_win = 0; m_idle = 0;
                end else if (stopev) begin
                    m_stopped++;
                    m_idle = 0;
                end else if (m_active) begin
                    m_idle++;
                end
                m_coin = newc;
            end
        end
    end

    // Every-cycle comparison against the reference
    always @(negedge CLK) begin
        int exp_gs, exp_st;
        if (chk_en) begin
            exp_gs = m_over ? 2 : (m_active ? 1 : 0);
            if (m_over || !m_active) exp_st = 7;
            else exp_st = (int'(m_stopped >= 1) << 2) | (int'(m_stopped >= 2) << 1) | int'(m_stopped >= 3);
            check("model_coin", int'(COIN), m_coin);
            check("model_gameset", int'(GAMESET), exp_gs);
            check("model_stops", int'({STOP1, STOP2, STOP3}), exp_st);
            check("model_win", int'(WIN), m_win);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_coin();
        @(negedge CLK) C_IN = 1'b1;
        @(negedge CLK) C_IN = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK) GAME_START = 1'b1;
        @(negedge CLK) GAME_START = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge CLK) STOP_BTN = 1'b1;
        @(negedge CLK) STOP_BTN = 1'b0;
    endtask

    task automatic set_reels(input int a, input int b, input int c);
        REEL1 = 4'(a); REEL2 = 4'(b); REEL3 = 4'(c);
    endtask

    task automatic play(input int a, input int b, input int c);
        set_reels(a, b, c);
        pulse_start();
        pulse_stop();
        pulse_stop();
        pulse_stop();
        tick(1);
    endtask

    task automatic do_reset();
        @(negedge CLK) RST = 1'b0;
        @(negedge CLK) RST = 1'b1;
    endtask

    initial begin
        RST = 1'b0; C_IN = 1'b0; GAME_START = 1'b0; STOP_BTN = 1'b0;
        set_reels(0, 0, 0);
        tick(2);
        RST = 1'b1;
        chk_en = 1'b1;
        tick(3);
        check("reset_coin", int'(COIN), 74);
        check("reset_gameset", int'(GAMESET), 0);
        check("reset_stops", int'({STOP1, STOP2, STOP3}), 7);
        check("reset_win", int'(WIN), 0);

        for (int i = 0; i < 3; i++) pulse_coin();
        check("three_coins", int'(COIN), 77);
        @(negedge CLK) C_IN = 1'b1;
        tick(10);
        C_IN = 1'b0;
        tick(1);
        check("held_coin", int'(COIN), 78);

        do_reset();
        set_reels(3, 3, 3);
        pulse_start();
        check("start_coin", int'(COIN), 73);
        check("start_gameset", int'(GAMESET), 1);
        check("start_stops", int'({STOP1, STOP2, STOP3}), 0);
        pulse_stop();
        check("stop_1", int'({STOP1, STOP2, STOP3}), 4);
        pulse_stop();
        check("stop_2", int'({STOP1, STOP2, STOP3}), 6);
        pulse_stop();
        check("stop_3", int'({STOP1, STOP2, STOP3}), 7);
        check("eval_gameset", int'(GAMESET), 1);
        tick(1);
        check("jackpot_coin", int'(COIN), 83);
        check("jackpot_win", int'(WIN), 2);
        check("jackpot_gameset", int'(GAMESET), 0);

        set_reels(5, 2, 5);
        pulse_start();
        pulse_start();
        check("start_in_spin_coin", int'(COIN), 82);
        check("start_in_spin_stops", int'({STOP1, STOP2, STOP3}), 0);
        pulse_stop(); pulse_stop(); pulse_stop();
        tick(1);
        check("pair_coin", int'(COIN), 84);
        check("pair_win", int'(WIN), 1);

        play(1, 2, 3);
        check("none_coin", int'(COIN), 83);
        check("none_win", int'(WIN), 0);

        set_reels(7, 7, 1);
        pulse_start();
        tick(7);
        check("auto_before_1", int'({STOP1, STOP2, STOP3}), 0);
        tick(1);
        check("auto_stop_1", int'({STOP1, STOP2, STOP3}), 4);
        tick(3);
        pulse_stop();
        check("btn_mid_count", int'({STOP1, STOP2, STOP3}), 6);
        tick(7);
        check("auto_before_3", int'({STOP1, STOP2, STOP3}), 6);
        tick(1);
        check("auto_stop_3", int'({STOP1, STOP2, STOP3}), 7);
        tick(1);
        check("auto_game_coin", int'(COIN), 84);

        for (int i = 0; i < 33; i++) play(1, 2, 3);
        check("drain_to_51", int'(COIN), 51);
        set_reels(5, 5, 2);
        pulse_start();
        check("start_at_50", int'(COIN), 50);
        pulse_stop(); pulse_stop(); pulse_stop();
        C_IN = 1'b1;
        @(negedge CLK) C_IN = 1'b0;
        check("coin_and_pair", int'(COIN), 53);
        check("coin_and_pair_win", int'(WIN), 1);

        pulse_start();
        pulse_stop();
        @(negedge CLK) RST = 1'b0;
        @(negedge CLK) RST = 1'b1;
        check("midgame_reset_coin", int'(COIN), 74);
        check("midgame_reset_gameset", int'(GAMESET), 0);
        check("midgame_reset_stops", int'({STOP1, STOP2, STOP3}), 7);

        for (int i = 0; i < 74; i++) play(1, 2, 3);
        check("drain_to_0", int'(COIN), 0);
        pulse_start();
        check("start_no_credit_gs", int'(GAMESET), 0);
        check("start_no_credit_stops", int'({STOP1, STOP2, STOP3}), 7);

        for (int i = 0; i < 95; i++) pulse_coin();
        check("fill_to_95", int'(COIN), 95);
        play(3, 3, 3);
        check("over_coin", int'(COIN), 99);
        check("over_gameset", int'(GAMESET), 2);
        pulse_coin();
        pulse_start();
        check("over_hold_coin", int'(COIN), 99);
        check("over_hold_gameset", int'(GAMESET), 2);

        do_reset();
        set_reels(1, 2, 3);
        pulse_start();
        pulse_stop();
        for (int i = 0; i < 26; i++) pulse_coin();
        tick(1);
        check("coin_to_99_coin", int'(COIN), 99);
        check("coin_to_99_gameset", int'(GAMESET), 2);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
